// File: rtl/ball_motion_if.sv
`default_nettype none
// ============================================================================
// Module   : ball_motion_if
// Brief    : Control/position bundle between the ball engine and its users.
//            Carries the pause input only when BALL_PAUSE_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
interface ball_motion_if;
    logic       start;
    logic [2:0] level;
    logic [7:0] platex;
    logic [5:0] platesize;
    logic [5:0] ballsize;
    logic [7:0] ballx;
    logic [6:0] bally;
    logic       running;
    logic       hit;
    logic       miss;
`ifdef BALL_PAUSE_EN
    logic       pause;

    modport master (
        output start, level, platex, platesize, ballsize, pause,
        input  ballx, bally, running, hit, miss
    );
    modport slave (
        input  start, level, platex, platesize, ballsize, pause,
        output ballx, bally, running, hit, miss
    );
`else
    modport master (
        output start, level, platex, platesize, ballsize,
        input  ballx, bally, running, hit, miss
    );
    modport slave (
        input  start, level, platex, platesize, ballsize,
        output ballx, bally, running, hit, miss
    );
`endif
endinterface
`default_nettype wire

// File: rtl/ball_motion.sv
`default_nettype none
// ============================================================================
// Module   : ball_motion
// Brief    : Breakout ball physics: level-paced stepping, wall/plate bounces,
//            hit/miss pulses. Optional pause input via macro BALL_PAUSE_EN.
// Revision : 1.0  initial release
// ============================================================================
module ball_motion #(
    parameter int TICK_DIV = 500000,
    parameter int FIELD_W  = 120,
    parameter int FIELD_H  = 120,
    parameter int PLATE_Y  = 105,
    parameter int SERVE_X  = 60,
    parameter int SERVE_Y  = 20
) (
    input  logic          clk,
    input  logic          reset,
    ball_motion_if.slave  bus
);

    localparam int                 C_CNT_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [C_CNT_W-1:0] C_BASE_LAST = C_CNT_W'(TICK_DIV - 1);
    localparam logic [8:0]         C_FIELD_W   = 9'(FIELD_W);
    localparam logic [8:0]         C_MISS_Y    = 9'(FIELD_H - 1);
    localparam logic [8:0]         C_PLATE_Y   = 9'(PLATE_Y);
    localparam logic [7:0]         C_SERVE_X   = 8'(SERVE_X);
    localparam logic [6:0]         C_SERVE_Y   = 7'(SERVE_Y);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [C_CNT_W-1:0] r_base,  w_base_nxt;
    logic [2:0]         r_step,  w_step_nxt;
    logic [7:0]         r_ballx, w_ballx_nxt;
    logic [6:0]         r_bally, w_bally_nxt;
    logic               r_dx,    w_dx_nxt;
    logic               r_dy,    w_dy_nxt;
    logic               r_hit,   w_hit_nxt;
    logic               r_miss,  w_miss_nxt;

    logic               w_pause;
    logic               w_tick;
    logic               w_step;
    logic [2:0]         w_limit;
    logic [8:0]         w_right;
    logic [8:0]         w_bottom;
    logic [8:0]         w_plate_r;
    logic               w_plate_row;
    logic               w_over_plate;

`ifdef BALL_PAUSE_EN
    assign w_pause = bus.pause;
`else
    assign w_pause = 1'b0;
`endif

    // ">=" rather than "==" so a level raised past the current count fires at the next tick
    assign w_limit = 3'd7 - bus.level;
    assign w_tick  = (r_state == S_RUN) && !w_pause && (r_base == C_BASE_LAST);
    assign w_step  = w_tick && (r_step >= w_limit);

    assign w_right      = {1'b0, r_ballx} + {3'b000, bus.ballsize};
    assign w_bottom     = {2'b00, r_bally} + {3'b000, bus.ballsize};
    assign w_plate_r    = {1'b0, bus.platex} + {3'b000, bus.platesize};
    assign w_plate_row  = ((w_bottom + 9'd1) == C_PLATE_Y);
    assign w_over_plate = (w_right >= {1'b0, bus.platex}) && ({1'b0, r_ballx} <= w_plate_r);

    always_comb begin
        w_state_nxt = r_state;
        w_base_nxt  = r_base;
        w_step_nxt  = r_step;
        w_ballx_nxt = r_ballx;
        w_bally_nxt = r_bally;
        w_dx_nxt    = r_dx;
        w_dy_nxt    = r_dy;
        w_hit_nxt   = 1'b0;
        w_miss_nxt  = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_ballx_nxt = C_SERVE_X;
                w_bally_nxt = C_SERVE_Y;
                w_dx_nxt    = 1'b1;
                w_dy_nxt    = 1'b1;
                w_base_nxt  = '0;
                w_step_nxt  = '0;
                if (bus.start) begin
                    w_state_nxt = S_RUN;
                end
            end

            S_RUN: begin
                if (!w_pause) begin
                    w_base_nxt = w_tick ? '0 : r_base + C_CNT_W'(1);
                    if (w_tick) begin
                        w_step_nxt = w_step ? 3'd0 : r_step + 3'd1;
                    end
                end

                if (w_step) begin
                    if (r_dx && (w_right >= C_FIELD_W)) begin
                        w_dx_nxt    = 1'b0;
                        w_ballx_nxt = r_ballx - 8'd1;
                    end else if (!r_dx && (r_ballx == 8'd0)) begin
                        w_dx_nxt    = 1'b1;
                        w_ballx_nxt = r_ballx + 8'd1;
                    end else begin
                        w_ballx_nxt = r_dx ? r_ballx + 8'd1 : r_ballx - 8'd1;
                    end

                    if (!r_dy && (r_bally == 7'd0)) begin
                        w_dy_nxt    = 1'b1;
                        w_bally_nxt = r_bally + 7'd1;
                    end else if (r_dy && w_plate_row && w_over_plate) begin
                        w_dy_nxt    = 1'b0;
                        w_bally_nxt = r_bally - 7'd1;
                        w_hit_nxt   = 1'b1;
                    end else if (r_dy && (w_bottom >= C_MISS_Y)) begin
                        // Miss overrides the x move: the ball is re-served on this edge
                        w_miss_nxt  = 1'b1;
                        w_state_nxt = S_IDLE;
                        w_ballx_nxt = C_SERVE_X;
                        w_bally_nxt = C_SERVE_Y;
                        w_dx_nxt    = 1'b1;
                        w_dy_nxt    = 1'b1;
                        w_base_nxt  = '0;
                        w_step_nxt  = '0;
                    end else begin
                        w_bally_nxt = r_dy ? r_bally + 7'd1 : r_bally - 7'd1;
                    end
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_base  <= '0;
            r_step  <= '0;
            r_ballx <= C_SERVE_X;
            r_bally <= C_SERVE_Y;
            r_dx    <= 1'b1;
            r_dy    <= 1'b1;
            r_hit   <= 1'b0;
            r_miss  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_base  <= w_base_nxt;
            r_step  <= w_step_nxt;
            r_ballx <= w_ballx_nxt;
            r_bally <= w_bally_nxt;
            r_dx    <= w_dx_nxt;
            r_dy    <= w_dy_nxt;
            r_hit   <= w_hit_nxt;
            r_miss  <= w_miss_nxt;
        end
    end

    assign bus.ballx   = r_ballx;
    assign bus.bally   = r_bally;
    assign bus.running = (r_state == S_RUN);
    assign bus.hit     = r_hit;
    assign bus.miss    = r_miss;

endmodule
`default_nettype wire

// File: tb/tb_ball_motion.sv
`default_nettype none
// ============================================================================
// Module   : tb_ball_motion
// Brief    : Directed bench for ball_motion with TICK_DIV=2 (one step every
//            2 cycles at level 7); expected positions are hand-computed.
// Revision : 1.0  initial release
// ============================================================================
module tb_ball_motion;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    ball_motion_if bif ();

    ball_motion #(
        .TICK_DIV (2),
        .FIELD_W  (120),
        .FIELD_H  (120),
        .PLATE_Y  (105),
        .SERVE_X  (60),
        .SERVE_Y  (20)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec = n_vec + 1;
        if (obs !== exp_v) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic chk_pos(input string tag, input int x, input int y);
        chk({tag, ".x"}, 32'(bif.ballx), 32'(x));
        chk({tag, ".y"}, 32'(bif.bally), 32'(y));
    endtask

    // Pulse start for one edge; returns 1 time unit after that edge
    task automatic serve();
        @(negedge clk);
        bif.start = 1'b1;
        @(posedge clk);
        #1;
        bif.start = 1'b0;
    endtask

    // At level 7 with TICK_DIV=2 a step lands on every second edge
    task automatic step_wait(input int n);
        repeat (2 * n) @(posedge clk);
        #1;
    endtask

    initial begin
        bif.start     = 1'b0;
        bif.level     = 3'd0;
        bif.platex    = 8'd0;
        bif.platesize = 6'd7;
        bif.ballsize  = 6'd3;
`ifdef BALL_PAUSE_EN
        bif.pause     = 1'b0;
`endif

        #2 reset = 1'b1;
        #1;
        chk_pos("reset", 60, 20);
        chk("reset.running", 32'(bif.running), 0);
        chk("reset.hit",     32'(bif.hit),     0);
        chk("reset.miss",    32'(bif.miss),    0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;

        // Level 0: first step 16 cycles after start
        serve();
        chk("l0.running", 32'(bif.running), 1);
        repeat (15) @(posedge clk);
        #1 chk_pos("l0.c15", 60, 20);
        @(posedge clk);
        #1 chk_pos("l0.c16", 61, 21);

        // Asynchronous reset in the middle of a cycle
        #2 reset = 1'b1;
        #1;
        chk_pos("areset", 60, 20);
        chk("areset.running", 32'(bif.running), 0);
        chk("areset.miss",    32'(bif.miss),    0);
        @(negedge clk) reset = 1'b0;

        // Level 7: right wall with ballsize 3, then descend into a miss
        bif.level = 3'd7;
        serve();
        step_wait(1);
        chk_pos("l7.s1", 61, 21);
        step_wait(56);
        chk_pos("wall.s57", 117, 77);
        step_wait(1);
        chk_pos("wall.s58", 116, 78);
        step_wait(1);
        chk_pos("wall.s59", 115, 79);
        step_wait(37);
        chk_pos("miss.s96", 78, 116);
        chk("miss.s96.miss", 32'(bif.miss), 0);
        step_wait(1);
        chk("miss.pulse",   32'(bif.miss),    1);
        chk("miss.running", 32'(bif.running), 0);
        chk("miss.hit",     32'(bif.hit),     0);
        chk_pos("miss.serve", 60, 20);
        @(posedge clk);
        #1 chk("miss.drop", 32'(bif.miss), 0);
        repeat (6) @(posedge clk);
        #1 chk_pos("idle.hold", 60, 20);

        // Re-serve; grow the ball so plate and right wall coincide on step 57
        serve();
        chk("reserve.running", 32'(bif.running), 1);
        step_wait(56);
        chk_pos("corner.s56", 116, 76);
        bif.ballsize  = 6'd28;
        bif.platex    = 8'd110;
        bif.platesize = 6'd15;
        step_wait(1);
        chk_pos("corner.s57", 115, 75);
        chk("corner.hit",     32'(bif.hit),     1);
        chk("corner.running", 32'(bif.running), 1);
        @(posedge clk);
        #1 chk("corner.hitdrop", 32'(bif.hit), 0);
        @(posedge clk);
        #1 chk_pos("corner.s58", 114, 74);

        // Raising the level past the current step count fires at the next tick
        #2 reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        bif.ballsize  = 6'd3;
        bif.platex    = 8'd0;
        bif.platesize = 6'd7;
        bif.level     = 3'd0;
        serve();
        repeat (6) @(posedge clk);
        #1 bif.level = 3'd7;
        @(posedge clk);
        #1 chk_pos("lvl.c7", 60, 20);
        @(posedge clk);
        #1 chk_pos("lvl.c8", 61, 21);

`ifdef BALL_PAUSE_EN
        bif.pause = 1'b1;
        repeat (20) @(posedge clk);
        #1 chk_pos("pause.hold", 61, 21);
        bif.pause = 1'b0;
        @(posedge clk);
        #1 chk_pos("pause.c1", 61, 21);
        @(posedge clk);
        #1 chk_pos("pause.c2", 62, 22);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
